// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter state encoding and the index-width helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEFAULT_MAX_BURST = 4;

  // An index into a single-entry set still needs one bit to exist as a signal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side signal bundle for the write-port arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SRC_W      = idx_w(NUM_SRC)
);

  logic [NUM_SRC-1:0]            i_src_valid;
  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data;
  logic [NUM_SRC-1:0]            o_src_ready;
  logic                          o_fifo_valid;
  logic [DATA_WIDTH-1:0]         o_fifo_data;
  logic                          i_fifo_ready;
  logic                          i_fifo_almostfull;
  logic [SRC_W-1:0]              o_grant;
  logic                          o_busy;

  modport slave (
    input  i_src_valid,
    input  i_src_data,
    input  i_fifo_ready,
    input  i_fifo_almostfull,
    output o_src_ready,
    output o_fifo_valid,
    output o_fifo_data,
    output o_grant,
    output o_busy
  );

  modport master (
    output i_src_valid,
    output i_src_data,
    output i_fifo_ready,
    output i_fifo_almostfull,
    input  o_src_ready,
    input  o_fifo_valid,
    input  o_fifo_data,
    input  o_grant,
    input  o_busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority selector: first requesting index at or above the
// pointer, wrapping modulo N. Purely combinational.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin : pick_scan
    int            w_k;
    logic [IW-1:0] w_kk;
    o_found = 1'b0;
    o_idx   = '0;
    w_k     = 0;
    w_kk    = '0;
    for (int off = N - 1; off >= 0; off--) begin
      w_k = int'(i_ptr) + off;
      if (w_k >= N) begin
        w_k = w_k - N;
      end
      w_kk = IW'(w_k);
      if (i_req[w_kk]) begin
        o_found = 1'b1;
        o_idx   = w_kk;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among
// NUM_SRC streaming requesters, throttled by the FIFO ready/almost-full flags.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int SRC_W = idx_w(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic [SRC_W-1:0]  r_grant;
  logic [SRC_W-1:0]  w_grant_next;
  logic [SRC_W-1:0]  r_rr_ptr;
  logic [SRC_W-1:0]  w_rr_ptr_next;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  w_beat_cnt_next;

  logic [DATA_WIDTH-1:0] w_src_data [NUM_SRC];
  logic                  w_cur_valid;
  logic                  w_beat;
  logic                  w_last_beat;
  logic                  w_release;
  logic [SRC_W-1:0]      w_ptr_after;
  logic [SRC_W-1:0]      w_pick_ptr;
  logic [SRC_W-1:0]      w_pick_idx;
  logic                  w_pick_found;

  logic [NUM_SRC-1:0]    w_src_ready;
  logic                  w_fifo_valid;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic                  w_busy;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_slice
      assign w_src_data[gi] = bus.i_src_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_cur_valid = bus.i_src_valid[r_grant];
  assign w_beat      = (r_state == GRANT) && w_cur_valid && bus.i_fifo_ready;
  assign w_last_beat = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  assign w_release   = (r_state == GRANT) &&
                       ((w_beat && (w_last_beat || bus.i_fifo_almostfull)) || !w_cur_valid);

  // Wrap at NUM_SRC-1 explicitly so non-power-of-two source counts stay in range.
  assign w_ptr_after = (r_grant == SRC_W'(NUM_SRC - 1)) ? '0 : r_grant + SRC_W'(1);
  assign w_pick_ptr  = (r_state == GRANT) ? w_ptr_after : r_rr_ptr;

  rr_pick #(
    .N  (NUM_SRC),
    .IW (SRC_W)
  ) u_rr_pick (
    .i_req   (bus.i_src_valid),
    .i_ptr   (w_pick_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_rr_ptr_next   = r_rr_ptr;
    w_beat_cnt_next = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_next    = GRANT;
          w_grant_next    = w_pick_idx;
          w_beat_cnt_next = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          // Hand over in the same cycle so back-to-back grants have no bubble.
          w_rr_ptr_next   = w_ptr_after;
          w_beat_cnt_next = '0;
          if (w_pick_found) begin
            w_grant_next = w_pick_idx;
          end else begin
            w_state_next = IDLE;
          end
        end else if (w_beat) begin
          w_beat_cnt_next = r_beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_src_ready  = '0;
    w_fifo_valid = 1'b0;
    w_fifo_data  = '0;
    w_busy       = 1'b0;
    if (r_state == GRANT) begin
      w_fifo_valid         = w_cur_valid;
      w_fifo_data          = w_src_data[r_grant];
      w_src_ready[r_grant] = bus.i_fifo_ready;
      w_busy               = 1'b1;
    end
  end

  assign bus.o_src_ready  = w_src_ready;
  assign bus.o_fifo_valid = w_fifo_valid;
  assign bus.o_fifo_data  = w_fifo_data;
  assign bus.o_grant      = r_grant;
  assign bus.o_busy       = w_busy;

  // Requesters must hold valid and data steady until accepted.
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src_contract
      a_hold : assert property (@(posedge clk) disable iff (!reset_n)
        (bus.i_src_valid[gi] && !w_src_ready[gi]) |=>
          (bus.i_src_valid[gi] && $stable(w_src_data[gi])));
    end
  endgenerate

  a_ready_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(w_src_ready));

endmodule
